clk_src_ctrl: RTL and testbench

- Supervisory FSM that sequences the clock-mux MMCM: it selects CLKINSEL, drives the MMCM reset, and monitors LOCKED.
- Replaces the raw XOR-pulse reset scheme with the following:
  - a minimum-width reset pulse;
  - a lock timeout with bounded retry;
  - a qualification holdoff before returning to the external clock;
  - a sticky fault.
- Sits in the clk_int (100 MHz) domain, between the clkStopTool/AXI register outputs and the MMCM.

---
 rtl/clk_src_ctrl_pkg.sv | 18 +
 rtl/clk_holdoff_filter.sv | 29 ++
 rtl/clk_src_ctrl.sv | 136 +++++++++++++
 tb/tb_clk_src_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_src_ctrl_pkg.sv
// Shared types and constants for the MMCM clock-source supervisor.
package clk_src_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } state_t;

  localparam logic CLKSEL_EXT = 1'b1;
  localparam logic CLKSEL_INT = 1'b0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/clk_holdoff_filter.sv
// Declares the external clock usable only after it has been running
// for HOLDOFF_CYCLES consecutive cycles without a stop indication.
module clk_holdoff_filter #(
  parameter int HOLDOFF_CYCLES = 1000000,
  parameter int CNT_W          = 24
) (
  input  logic clk,
  input  logic aresetn,
  input  logic ext_stopped,
  output logic ext_ok
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLDOFF_CYCLES);

  logic [CNT_W-1:0] hold_cnt;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      hold_cnt <= '0;
    end else if (ext_stopped) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign ext_ok = (hold_cnt == HOLD_MAX);

endmodule

// File: rtl/clk_src_ctrl.sv
// Supervisory FSM for the clock-mux MMCM: picks CLKINSEL, pulses the MMCM
// reset, waits for LOCKED with bounded retries and latches a fault.
module clk_src_ctrl
  import clk_src_ctrl_pkg::*;
#(
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT   = 100000,
  parameter int HOLDOFF_CYCLES = 1000000,
  parameter int MAX_RETRY      = 3,
  parameter int CNT_W          = 24
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        ext_stopped,
  input  logic        int_select,
  input  logic        mmcm_locked,
  input  logic        clear_fault,
  output logic        clkinsel,
  output logic        mmcm_reset,
  output logic        locked_out,
  output logic        fault,
  output logic [1:0]  state_out,
  output logic [15:0] switch_count
);

  localparam int               RETRY_W   = $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_t             state;
  logic [CNT_W-1:0]   timer;
  logic [RETRY_W-1:0] retry;
  logic [RETRY_W-1:0] retry_next;
  logic               ext_ok;
  logic               target;
  logic               lock_meta;
  logic               lock_sync;

  clk_holdoff_filter #(
    .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
    .CNT_W          (CNT_W)
  ) u_holdoff (
    .clk         (clk),
    .aresetn     (aresetn),
    .ext_stopped (ext_stopped),
    .ext_ok      (ext_ok)
  );

  // Two-stage synchronizer for the asynchronous LOCKED output.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= mmcm_locked;
      lock_sync <= lock_meta;
    end
  end

  assign target     = ext_ok && !int_select;
  assign retry_next = retry + 1'b1;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= ST_RESET;
      timer        <= '0;
      retry        <= '0;
      clkinsel     <= CLKSEL_INT;
      switch_count <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          if (target != clkinsel) begin
            clkinsel     <= target;
            timer        <= '0;
            switch_count <= sat_inc16(switch_count);
          end else if (timer == RST_LAST) begin
            state <= ST_WAIT_LOCK;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (target != clkinsel) begin
            state        <= ST_RESET;
            clkinsel     <= target;
            timer        <= '0;
            switch_count <= sat_inc16(switch_count);
          end else if (lock_sync) begin
            state <= ST_RUN;
            retry <= '0;
            timer <= '0;
          end else if (timer == LOCK_LAST) begin
            retry <= retry_next;
            timer <= '0;
            state <= (retry_next == RETRY_MAX) ? ST_FAULT : ST_RESET;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RUN: begin
          // A source change outranks lock loss so it is counted exactly once.
          if (target != clkinsel) begin
            state        <= ST_RESET;
            clkinsel     <= target;
            timer        <= '0;
            switch_count <= sat_inc16(switch_count);
          end else if (!lock_sync) begin
            state <= ST_RESET;
            timer <= '0;
          end
        end
        ST_FAULT: begin
          if (clear_fault || (target != clkinsel)) begin
            state    <= ST_RESET;
            clkinsel <= target;
            retry    <= '0;
            timer    <= '0;
            if (target != clkinsel) begin
              switch_count <= sat_inc16(switch_count);
            end
          end
        end
        default: state <= ST_RESET;
      endcase
    end
  end

  assign mmcm_reset = (state == ST_RESET) || (state == ST_FAULT);
  assign fault      = (state == ST_FAULT);
  assign locked_out = (state == ST_RUN) && lock_sync;
  assign state_out  = state;

endmodule

// File: tb/tb_clk_src_ctrl.sv
// Directed bench for clk_src_ctrl: cycle-exact expectations for power-up,
// source switching, holdoff, lock timeout/fault, lock glitch and async reset.
module tb_clk_src_ctrl;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        ext_stopped;
  logic        int_select;
  logic        mmcm_locked;
  logic        clear_fault;
  logic        clkinsel;
  logic        mmcm_reset;
  logic        locked_out;
  logic        fault;
  logic [1:0]  state_out;
  logic [15:0] switch_count;

  int check_count = 0;
  int fail_count  = 0;

  clk_src_ctrl #(
    .RST_CYCLES     (4),
    .LOCK_TIMEOUT   (50),
    .HOLDOFF_CYCLES (20),
    .MAX_RETRY      (2),
    .CNT_W          (24)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .ext_stopped  (ext_stopped),
    .int_select   (int_select),
    .mmcm_locked  (mmcm_locked),
    .clear_fault  (clear_fault),
    .clkinsel     (clkinsel),
    .mmcm_reset   (mmcm_reset),
    .locked_out   (locked_out),
    .fault        (fault),
    .state_out    (state_out),
    .switch_count (switch_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic stop, input logic isel, input logic lock);
    ext_stopped = stop;
    int_select  = isel;
    mmcm_locked = lock;
  endtask

  initial begin
    aresetn     = 1'b0;
    clear_fault = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(3);
    checkOutput("rst_state", 32'(state_out), 32'd0);
    checkOutput("rst_clkinsel", 32'(clkinsel), 32'd0);
    checkOutput("rst_mmcm_reset", 32'(mmcm_reset), 32'd1);
    checkOutput("rst_locked", 32'(locked_out), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_count", 32'(switch_count), 32'd0);

    // Power-up: 4-cycle reset pulse, lock on internal, then move to ext.
    aresetn = 1'b1;
    tick(3);
    checkOutput("pu_reset_e3", 32'(state_out), 32'd0);
    tick(1);
    checkOutput("pu_wait_e4", 32'(state_out), 32'd1);
    checkOutput("pu_mmcm_rel", 32'(mmcm_reset), 32'd0);
    tick(6);
    mmcm_locked = 1'b1;
    tick(2);
    checkOutput("pu_wait_e12", 32'(state_out), 32'd1);
    tick(1);
    checkOutput("pu_run_e13", 32'(state_out), 32'd2);
    checkOutput("pu_locked_e13", 32'(locked_out), 32'd1);
    checkOutput("pu_int_e13", 32'(clkinsel), 32'd0);
    tick(7);
    checkOutput("pu_int_e20", 32'(clkinsel), 32'd0);
    tick(1);
    checkOutput("pu_sw_state", 32'(state_out), 32'd0);
    checkOutput("pu_sw_ext", 32'(clkinsel), 32'd1);
    checkOutput("pu_sw_count", 32'(switch_count), 32'd1);
    checkOutput("pu_sw_locked", 32'(locked_out), 32'd0);
    mmcm_locked = 1'b0;
    tick(3);
    checkOutput("pu_sw_e24", 32'(state_out), 32'd0);
    tick(1);
    checkOutput("pu_sw_e25", 32'(state_out), 32'd1);
    tick(2);
    mmcm_locked = 1'b1;
    tick(3);
    checkOutput("pu_ext_run", 32'(state_out), 32'd2);
    checkOutput("pu_ext_locked", 32'(locked_out), 32'd1);

    // Ext clock stops: fall back to internal two edges later.
    ext_stopped = 1'b1;
    tick(1);
    checkOutput("stop_e1_sel", 32'(clkinsel), 32'd1);
    checkOutput("stop_e1_rst", 32'(mmcm_reset), 32'd0);
    tick(1);
    checkOutput("stop_e2_sel", 32'(clkinsel), 32'd0);
    checkOutput("stop_e2_rst", 32'(mmcm_reset), 32'd1);
    checkOutput("stop_e2_count", 32'(switch_count), 32'd2);
    checkOutput("stop_e2_locked", 32'(locked_out), 32'd0);
    mmcm_locked = 1'b0;
    tick(3);
    checkOutput("stop_reset_4", 32'(state_out), 32'd0);
    tick(1);
    checkOutput("stop_wait", 32'(state_out), 32'd1);
    mmcm_locked = 1'b1;
    tick(3);
    checkOutput("stop_run", 32'(state_out), 32'd2);
    checkOutput("stop_locked", 32'(locked_out), 32'd1);

    // Ext toggling faster than the holdoff must never be reselected.
    for (int i = 0; i < 20; i++) begin
      ext_stopped = ~ext_stopped;
      tick(10);
      checkOutput("toggle_sel", 32'(clkinsel), 32'd0);
    end
    checkOutput("toggle_count", 32'(switch_count), 32'd2);
    checkOutput("toggle_state", 32'(state_out), 32'd2);

    // Lock never returns: two timed-out attempts, then FAULT.
    mmcm_locked = 1'b0;
    tick(2);
    checkOutput("to_lost_locked", 32'(locked_out), 32'd0);
    tick(1);
    checkOutput("to_reset", 32'(state_out), 32'd0);
    tick(3);
    checkOutput("to_reset_f6", 32'(state_out), 32'd0);
    tick(1);
    checkOutput("to_wait_f7", 32'(state_out), 32'd1);
    tick(49);
    checkOutput("to_wait_f56", 32'(state_out), 32'd1);
    tick(1);
    checkOutput("to_retry_reset", 32'(state_out), 32'd0);
    tick(3);
    checkOutput("to_retry_f60", 32'(state_out), 32'd0);
    tick(1);
    checkOutput("to_wait_f61", 32'(state_out), 32'd1);
    tick(49);
    checkOutput("to_wait_f110", 32'(state_out), 32'd1);
    tick(1);
    checkOutput("fault_state", 32'(state_out), 32'd3);
    checkOutput("fault_flag", 32'(fault), 32'd1);
    checkOutput("fault_mmcm_rst", 32'(mmcm_reset), 32'd1);
    checkOutput("fault_count", 32'(switch_count), 32'd2);
    tick(5);
    checkOutput("fault_sticky", 32'(state_out), 32'd3);
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    checkOutput("clr_state", 32'(state_out), 32'd0);
    checkOutput("clr_fault", 32'(fault), 32'd0);
    checkOutput("clr_count", 32'(switch_count), 32'd2);
    mmcm_locked = 1'b1;
    tick(5);
    checkOutput("clr_run", 32'(state_out), 32'd2);

    // Let ext qualify again so the lock-glitch case runs on ext.
    ext_stopped = 1'b0;
    tick(20);
    checkOutput("req_hold_sel", 32'(clkinsel), 32'd0);
    tick(1);
    checkOutput("req_sel", 32'(clkinsel), 32'd1);
    checkOutput("req_count", 32'(switch_count), 32'd3);
    tick(5);
    checkOutput("req_run", 32'(state_out), 32'd2);

    // One-cycle LOCKED glitch: re-lock on the same source, no count.
    mmcm_locked = 1'b0;
    tick(1);
    mmcm_locked = 1'b1;
    tick(1);
    checkOutput("gl_locked_low", 32'(locked_out), 32'd0);
    checkOutput("gl_still_run", 32'(state_out), 32'd2);
    tick(1);
    checkOutput("gl_reset", 32'(state_out), 32'd0);
    checkOutput("gl_sel", 32'(clkinsel), 32'd1);
    checkOutput("gl_count", 32'(switch_count), 32'd3);
    tick(5);
    checkOutput("gl_run", 32'(state_out), 32'd2);

    // int_select and lock loss seen together: one RESET entry, one count.
    mmcm_locked = 1'b0;
    tick(2);
    int_select = 1'b1;
    tick(1);
    checkOutput("both_state", 32'(state_out), 32'd0);
    checkOutput("both_sel", 32'(clkinsel), 32'd0);
    checkOutput("both_count", 32'(switch_count), 32'd4);
    tick(1);
    checkOutput("both_count_2", 32'(switch_count), 32'd4);
    tick(3);
    checkOutput("both_wait", 32'(state_out), 32'd1);
    tick(2);
    checkOutput("both_wait_2", 32'(state_out), 32'd1);
    checkOutput("both_mmcm_rel", 32'(mmcm_reset), 32'd0);

    // Async reset mid-WAIT_LOCK, sampled between clock edges.
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("ar_state", 32'(state_out), 32'd0);
    checkOutput("ar_mmcm_rst", 32'(mmcm_reset), 32'd1);
    checkOutput("ar_sel", 32'(clkinsel), 32'd0);
    checkOutput("ar_count", 32'(switch_count), 32'd0);
    checkOutput("ar_fault", 32'(fault), 32'd0);
    checkOutput("ar_locked", 32'(locked_out), 32'd0);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
